// File: rtl/microwave_panel_input.sv
// ---------------------------------------------------------------------------
// microwave_panel_input
//   Front-panel input conditioner for the microwave controller. Every raw
//   switch/key is brought into the clock domain with a two-flop synchronizer,
//   debounced, and (where needed) turned into a single-cycle rise pulse.
//   The pulses drive the start/cancel outputs, the power toggle and the
//   cook-time accumulator.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   raw_start      in   raw start key, 1 = pressed
//   raw_cancel     in   raw cancel key, 1 = pressed
//   raw_door       in   raw door switch, 1 = closed
//   raw_power_sel  in   raw power-select key, 1 = pressed
//   raw_add10      in   raw +10 s key
//   raw_add1       in   raw +1 s key
//   busy           in   controller is cooking; gates panel actions
//   start_button   out  one-cycle accepted start pulse
//   cancel_button  out  one-cycle cancel pulse
//   door_status    out  debounced door level, 1 = closed
//   power          out  power level, 0 = HALF, 1 = FULL
//   timer[6:0]     out  programmed cook time in seconds
//   start_rejected out  one-cycle pulse for a refused start press
// ---------------------------------------------------------------------------
module microwave_panel_input #(
  parameter int DB_CYCLES = 4,
  parameter int MAX_TIME  = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_start,
  input  logic       raw_cancel,
  input  logic       raw_door,
  input  logic       raw_power_sel,
  input  logic       raw_add10,
  input  logic       raw_add1,
  input  logic       busy,
  output logic       start_button,
  output logic       cancel_button,
  output logic       door_status,
  output logic       power,
  output logic [6:0] timer,
  output logic       start_rejected
);

  localparam int NCH       = 6;
  localparam int CH_START  = 0;
  localparam int CH_CANCEL = 1;
  localparam int CH_DOOR   = 2;
  localparam int CH_POWER  = 3;
  localparam int CH_ADD10  = 4;
  localparam int CH_ADD1   = 5;

  localparam int              CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [7:0]      MAX_T    = 8'(MAX_TIME);

  // Clamp the 8-bit sum to the cook-time ceiling; never wraps past 127.
  function automatic logic [6:0] sat_time(input logic [7:0] v);
    if (v > MAX_T) begin
      return MAX_T[6:0];
    end
    return v[6:0];
  endfunction

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;
  logic [NCH-1:0] r_db;
  logic [NCH-1:0] r_db_d;
  logic [NCH-1:0] r_rise;
  logic [CW-1:0]  r_cnt [NCH];

  logic [6:0]     r_timer;
  logic           r_power;

  logic [7:0]     w_inc;
  logic [7:0]     w_sum;
  logic           w_start_ok;

  assign w_raw = {raw_add1, raw_add10, raw_power_sel, raw_door, raw_cancel, raw_start};

  // --- stage: synchronize, debounce, detect debounced rise ---------------
  // A channel's level flips only after its synchronized value has differed
  // from the current level on DB_CYCLES consecutive edges; any sample that
  // agrees with the level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      r_rise  <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      r_rise  <= r_db & ~r_db_d;
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // --- stage: pulse-cycle actions (gated by busy in the pulse cycle) -----
  // Both add keys may rise together; the sum is formed at 8 bits so the
  // saturation sees the true value.
  assign w_inc = (r_rise[CH_ADD10] ? 8'd10 : 8'd0) + (r_rise[CH_ADD1] ? 8'd1 : 8'd0);
  assign w_sum = {1'b0, r_timer} + w_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_power <= 1'b0;
    end else if (!busy) begin
      // Cancel clears the timer and overrides any add in the same cycle.
      if (r_rise[CH_CANCEL]) begin
        r_timer <= '0;
      end else if (r_rise[CH_ADD10] || r_rise[CH_ADD1]) begin
        r_timer <= sat_time(w_sum);
      end
      if (r_rise[CH_POWER]) begin
        r_power <= ~r_power;
      end
    end
  end

  // A start press is accepted only with the door closed, a non-zero time,
  // the controller idle, and no cancel arriving in the same cycle.
  assign w_start_ok = r_db[CH_DOOR] && (r_timer != 7'd0) && !busy && !r_rise[CH_CANCEL];

  assign start_button   = r_rise[CH_START] & w_start_ok;
  assign start_rejected = r_rise[CH_START] & ~w_start_ok;
  assign cancel_button  = r_rise[CH_CANCEL];
  assign door_status    = r_db[CH_DOOR];
  assign power          = r_power;
  assign timer          = r_timer;

endmodule

// File: tb/tb_microwave_panel_input.sv
module tb_microwave_panel_input;

  localparam int DB   = 4;
  localparam int MAXT = 120;

  localparam logic [5:0] S = 6'd1;   // start
  localparam logic [5:0] C = 6'd2;   // cancel
  localparam logic [5:0] D = 6'd4;   // door closed
  localparam logic [5:0] P = 6'd8;   // power select
  localparam logic [5:0] T = 6'd16;  // +10 s
  localparam logic [5:0] O = 6'd32;  // +1 s

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       busy  = 1'b0;
  logic [5:0] raw   = '0;

  logic       start_button, cancel_button, door_status, power, start_rejected;
  logic [6:0] timer;

  microwave_panel_input #(.DB_CYCLES(DB), .MAX_TIME(MAXT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raw_start     (raw[0]),
    .raw_cancel    (raw[1]),
    .raw_door      (raw[2]),
    .raw_power_sel (raw[3]),
    .raw_add10     (raw[4]),
    .raw_add1      (raw[5]),
    .busy          (busy),
    .start_button  (start_button),
    .cancel_button (cancel_button),
    .door_status   (door_status),
    .power         (power),
    .timer         (timer),
    .start_rejected(start_rejected)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_start, n_rej, n_cancel;

  // Reference model: a key's level flips once the last DB synchronized
  // samples (raw delayed by two edges) all disagree with it; a rising level
  // produces an event visible the next cycle, and that event acts on the
  // timer/power at the edge closing its cycle.
  bit       m_hist [6][DB+2];
  bit [5:0] m_db, m_rose, m_pulse;
  int       m_timer;
  bit       m_power;

  typedef struct {
    logic [5:0] raw;
    logic       busy;
    int         hold;
    int         e_timer;
    logic       e_power;
    logic       e_door;
    int         e_start;
    int         e_rej;
    int         e_cancel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [5:0] r, logic b, int h, int et, logic ep, logic ed,
                              int es, int er, int ec);
    vec_t v;
    v.raw = r; v.busy = b; v.hold = h; v.e_timer = et; v.e_power = ep; v.e_door = ed;
    v.e_start = es; v.e_rej = er; v.e_cancel = ec;
    return v;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 6; c++)
      for (int j = 0; j < DB + 2; j++) m_hist[c][j] = 1'b0;
    m_db = '0; m_rose = '0; m_pulse = '0; m_timer = 0; m_power = 1'b0;
  endtask

  task automatic model_edge();
    int  add;
    bit  all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!busy) begin
      if (m_pulse[1]) m_timer = 0;
      else begin
        add = (m_pulse[4] ? 10 : 0) + (m_pulse[5] ? 1 : 0);
        if (add != 0) m_timer = imin(m_timer + add, MAXT);
      end
      if (m_pulse[3]) m_power = !m_power;
    end
    m_pulse = m_rose;
    for (int c = 0; c < 6; c++) begin
      for (int j = DB + 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
      m_hist[c][0] = raw[c];
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++)
        if (m_hist[c][j] == m_db[c]) all_diff = 1'b0;
      m_rose[c] = 1'b0;
      if (all_diff) begin
        m_rose[c] = !m_db[c];
        m_db[c]   = !m_db[c];
      end
    end
  endtask

  task automatic check_model();
    logic       e_start, e_rej;
    logic [11:0] act, exp;
    e_start = m_pulse[0] && !m_pulse[1] && m_db[2] && (m_timer != 0) && !busy;
    e_rej   = m_pulse[0] && !e_start;
    act = {start_button, cancel_button, door_status, power, start_rejected, timer};
    exp = {e_start, m_pulse[1], m_db[2], m_power, e_rej, 7'(m_timer)};
    chk("outputs_vs_model", int'(act), int'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
    n_start  += int'(start_button);
    n_rej    += int'(start_rejected);
    n_cancel += int'(cancel_button);
  endtask

  task automatic press(input logic [5:0] m);
    raw = m;
    repeat (8) tick();
    raw = D;
    repeat (8) tick();
  endtask

  task automatic clear_counts();
    n_start = 0; n_rej = 0; n_cancel = 0;
  endtask

  initial begin
    int rate [6];
    rate = '{6, 40, 20, 10, 8, 8};

    // Vector table: {raw, busy, cycles, timer, power, door, #start, #rejected, #cancel}
    vecs.push_back(mk(6'd0,  0, 4, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(D,     0, 8, 0,   0, 1, 0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      vecs.push_back(mk(D | T, 0, 8, imin(10 * (i + 1), MAXT), 0, 1, 0, 0, 0));
      vecs.push_back(mk(D,     0, 8, imin(10 * (i + 1), MAXT), 0, 1, 0, 0, 0));
    end
    vecs.push_back(mk(D | S, 0, 8, 120, 0, 1, 1, 0, 0));
    vecs.push_back(mk(D,     0, 8, 120, 0, 1, 0, 0, 0));
    vecs.push_back(mk(6'd0,  0, 8, 120, 0, 0, 0, 0, 0));
    vecs.push_back(mk(S,     0, 8, 120, 0, 0, 0, 1, 0));
    vecs.push_back(mk(6'd0,  0, 8, 120, 0, 0, 0, 0, 0));
    vecs.push_back(mk(D,     0, 8, 120, 0, 1, 0, 0, 0));
    vecs.push_back(mk(D | P, 0, 8, 120, 1, 1, 0, 0, 0));
    vecs.push_back(mk(D,     0, 8, 120, 1, 1, 0, 0, 0));
    vecs.push_back(mk(D | P, 1, 8, 120, 1, 1, 0, 0, 0));
    vecs.push_back(mk(D,     1, 8, 120, 1, 1, 0, 0, 0));
    vecs.push_back(mk(D | O, 1, 8, 120, 1, 1, 0, 0, 0));
    vecs.push_back(mk(D,     1, 8, 120, 1, 1, 0, 0, 0));
    vecs.push_back(mk(D | S, 1, 8, 120, 1, 1, 0, 1, 0));
    vecs.push_back(mk(D,     1, 8, 120, 1, 1, 0, 0, 0));
    vecs.push_back(mk(D | C, 1, 8, 120, 1, 1, 0, 0, 1));
    vecs.push_back(mk(D,     1, 8, 120, 1, 1, 0, 0, 0));
    vecs.push_back(mk(D | C, 0, 8, 0,   1, 1, 0, 0, 1));
    vecs.push_back(mk(D,     0, 8, 0,   1, 1, 0, 0, 0));
    vecs.push_back(mk(D | S, 0, 8, 0,   1, 1, 0, 1, 0));
    vecs.push_back(mk(D,     0, 8, 0,   1, 1, 0, 0, 0));
    vecs.push_back(mk(D | O, 0, 8, 1,   1, 1, 0, 0, 0));
    vecs.push_back(mk(D,     0, 8, 1,   1, 1, 0, 0, 0));
    vecs.push_back(mk(D | S | C, 0, 8, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(D,     0, 8, 0,   1, 1, 0, 0, 0));

    // Reset state
    #1 rst_n = 1'b0;
    model_reset();
    clear_counts();
    repeat (3) @(negedge clk);
    chk("reset_start_button",   int'(start_button),   0);
    chk("reset_cancel_button",  int'(cancel_button),  0);
    chk("reset_door_status",    int'(door_status),    0);
    chk("reset_power",          int'(power),          0);
    chk("reset_timer",          int'(timer),          0);
    chk("reset_start_rejected", int'(start_rejected), 0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      raw  = vecs[i].raw;
      busy = vecs[i].busy;
      clear_counts();
      repeat (vecs[i].hold) tick();
      chk($sformatf("vec%0d_timer", i),    int'(timer),       vecs[i].e_timer);
      chk($sformatf("vec%0d_power", i),    int'(power),       int'(vecs[i].e_power));
      chk($sformatf("vec%0d_door", i),     int'(door_status), int'(vecs[i].e_door));
      chk($sformatf("vec%0d_start", i),    n_start,           vecs[i].e_start);
      chk($sformatf("vec%0d_rejected", i), n_rej,             vecs[i].e_rej);
      chk($sformatf("vec%0d_cancel", i),   n_cancel,          vecs[i].e_cancel);
    end

    // Glitchy start press never completes a debounce; a clean 4-cycle press
    // yields exactly one pulse, six edges after the first sampled high.
    busy = 1'b0;
    press(D | O);
    chk("glitch_setup_timer", int'(timer), 1);
    clear_counts();
    raw = D | S; repeat (3) tick();
    raw = D;     repeat (1) tick();
    raw = D | S; repeat (3) tick();
    raw = D;     repeat (10) tick();
    chk("glitch_no_start", n_start, 0);
    chk("glitch_no_reject", n_rej, 0);
    raw = D | S; repeat (4) tick();
    raw = D;     repeat (2) tick();
    chk("start_before_k6", int'(start_button), 0);
    tick();
    chk("start_at_k6", int'(start_button), 1);
    chk("start_at_k6_not_rejected", int'(start_rejected), 0);
    tick();
    chk("start_after_k6", int'(start_button), 0);
    repeat (8) tick();

    // Cancel and +1 s together at timer 45: cancel wins
    press(D | C);
    for (int i = 0; i < 4; i++) press(D | T);
    for (int i = 0; i < 5; i++) press(D | O);
    chk("timer_45", int'(timer), 45);
    clear_counts();
    press(D | C | O);
    chk("cancel_add1_pulse", n_cancel, 1);
    chk("cancel_add1_timer", int'(timer), 0);

    // Reset asserted mid-debounce
    press(D | T);
    chk("pre_reset_timer", int'(timer), 10);
    raw = D | T;
    repeat (3) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs",
        int'({start_button, cancel_button, door_status, power, start_rejected, timer}), 0);
    raw = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    clear_counts();
    repeat (12) tick();
    chk("post_reset_no_start", n_start + n_rej, 0);
    chk("post_reset_no_cancel", n_cancel, 0);
    chk("post_reset_timer", int'(timer), 0);
    chk("post_reset_door", int'(door_status), 0);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 6; ch++)
        if ($urandom_range(0, rate[ch] - 1) == 0) raw[ch] = ~raw[ch];
      if ($urandom_range(0, 31) == 0) busy = ~busy;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
